// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter.
// Merges the main pipeline write port with two buffered secondary requesters
// (mul-div and load-return) onto a single register-file write port.
//
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   p_we/p_waddr/p_wdata pipeline write-back (highest priority, never stalled here)
//   md_valid/md_ready, md_waddr/md_wdata   mul-div write request handshake
//   ld_valid/ld_ready, ld_waddr/ld_wdata   load-return write request handshake
//   we/waddr/wdata      register-file write port
//   stall_o             a buffered write has waited STARVE_LIMIT cycles or more
//   pend_mask           one bit per register with a buffered, unwritten write
module regfile_wb_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_we,
  input  logic [4:0]  p_waddr,
  input  logic [31:0] p_wdata,
  input  logic        md_valid,
  output logic        md_ready,
  input  logic [4:0]  md_waddr,
  input  logic [31:0] md_wdata,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_waddr,
  input  logic [31:0] ld_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic        stall_o,
  output logic [31:0] pend_mask
);

  // Index 0 is the mul-div buffer, index 1 the load-return buffer.
  logic [1:0]        full_q, full_d;
  logic [1:0][4:0]   addr_q, addr_d;
  logic [1:0][31:0]  data_q, data_d;
  logic [1:0][3:0]   cnt_q, cnt_d;
  // Set when the mul-div entry is older than the load-return entry.
  logic              md_old_q, md_old_d;

  logic [1:0]        x_valid;
  logic [1:0][4:0]   x_addr;
  logic [1:0][31:0]  x_data;
  logic [1:0]        acc;
  logic [1:0]        grant;
  logic              p_win;
  logic              sel_md;

  assign x_valid = {ld_valid, md_valid};
  assign x_addr  = {ld_waddr, md_waddr};
  assign x_data  = {ld_wdata, md_wdata};

  assign md_ready = ~full_q[0];
  assign ld_ready = ~full_q[1];

  // Port selection and write-port drive.
  always_comb begin
    // Gating with rst keeps the write port quiet while reset is asserted.
    p_win  = rst & p_we & (p_waddr != 5'd0);
    sel_md = full_q[0] & (~full_q[1] | md_old_q);
    grant  = 2'b00;
    if (!p_win) begin
      if (sel_md) begin
        grant[0] = 1'b1;
      end else if (full_q[1]) begin
        grant[1] = 1'b1;
      end
    end

    we    = 1'b0;
    waddr = 5'd0;
    wdata = 32'd0;
    if (p_win) begin
      we    = 1'b1;
      waddr = p_waddr;
      wdata = p_wdata;
    end else if (grant[0]) begin
      we    = 1'b1;
      waddr = addr_q[0];
      wdata = data_q[0];
    end else if (grant[1]) begin
      we    = 1'b1;
      waddr = addr_q[1];
      wdata = data_q[1];
    end
  end

  // Buffer next state, starvation and pending mask.
  always_comb begin
    full_d    = full_q;
    addr_d    = addr_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    acc       = 2'b00;
    stall_o   = 1'b0;
    pend_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      // Writes to r0 complete the handshake but are dropped.
      acc[i] = x_valid[i] & ~full_q[i] & (x_addr[i] != 5'd0);
      if (acc[i]) begin
        full_d[i] = 1'b1;
        addr_d[i] = x_addr[i];
        data_d[i] = x_data[i];
        cnt_d[i]  = 4'd0;
      end else if (grant[i]) begin
        full_d[i] = 1'b0;
        cnt_d[i]  = 4'd0;
      end else if (full_q[i] && (cnt_q[i] != 4'hf)) begin
        cnt_d[i] = cnt_q[i] + 4'd1;
      end
      if (full_q[i]) begin
        pend_mask = pend_mask | (32'd1 << addr_q[i]);
        if ({28'd0, cnt_q[i]} >= STARVE_LIMIT) begin
          stall_o = 1'b1;
        end
      end
    end

    // Only meaningful while both entries are full; an lone new entry
    // overwrites it harmlessly. Same-cycle acceptance leaves mul-div older.
    md_old_d = md_old_q;
    if (acc[1]) begin
      md_old_d = 1'b1;
    end else if (acc[0]) begin
      md_old_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      full_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
      md_old_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      cnt_q    <= cnt_d;
      md_old_q <= md_old_d;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned Limit = 4;

  logic        clk;
  logic        rst;
  logic        p_we;
  logic [4:0]  p_waddr;
  logic [31:0] p_wdata;
  logic        md_valid, md_ready;
  logic [4:0]  md_waddr;
  logic [31:0] md_wdata;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        stall_o;
  logic [31:0] pend_mask;

  regfile_wb_arbiter #(.STARVE_LIMIT(Limit)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .p_we      (p_we),
    .p_waddr   (p_waddr),
    .p_wdata   (p_wdata),
    .md_valid  (md_valid),
    .md_ready  (md_ready),
    .md_waddr  (md_waddr),
    .md_wdata  (md_wdata),
    .ld_valid  (ld_valid),
    .ld_ready  (ld_ready),
    .ld_waddr  (ld_waddr),
    .ld_wdata  (ld_wdata),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .stall_o   (stall_o),
    .pend_mask (pend_mask)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  // Reference model: each requester holds at most one pending write, tagged
  // with a global acceptance sequence number; the smallest number is oldest.
  bit          m_full [2];
  logic [4:0]  m_addr [2];
  logic [31:0] m_data [2];
  int unsigned m_wait [2];
  int unsigned m_seq  [2];
  int unsigned seq_ctr;

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_full[i] = 0;
      m_wait[i] = 0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_we"}, {31'd0, we}, 32'd0);
    check_eq({tag, "_waddr"}, {27'd0, waddr}, 32'd0);
    check_eq({tag, "_wdata"}, wdata, 32'd0);
    check_eq({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    check_eq({tag, "_pend"}, pend_mask, 32'd0);
    check_eq({tag, "_md_ready"}, {31'd0, md_ready}, 32'd1);
    check_eq({tag, "_ld_ready"}, {31'd0, ld_ready}, 32'd1);
  endtask

  // Drive one cycle (called at posedge+1), check outputs at the negedge,
  // then advance the model to the next posedge.
  task automatic run_cycle(input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                           input logic mv, input logic [4:0] ma, input logic [31:0] mdat,
                           input logic lv, input logic [4:0] la, input logic [31:0] ldat);
    bit          e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [31:0] e_pend;
    bit          e_stall;
    int          pick;
    bit          xv [2];
    logic [4:0]  xa [2];
    logic [31:0] xd [2];
    p_we = pwe; p_waddr = pa; p_wdata = pd;
    md_valid = mv; md_waddr = ma; md_wdata = mdat;
    ld_valid = lv; ld_waddr = la; ld_wdata = ldat;
    #4;
    pick = -1;
    if (!(pwe && pa != 0)) begin
      for (int i = 0; i < 2; i++)
        if (m_full[i] && (pick < 0 || m_seq[i] < m_seq[pick])) pick = i;
    end
    e_we = 0; e_addr = 0; e_data = 0;
    if (pwe && pa != 0) begin
      e_we = 1; e_addr = pa; e_data = pd;
    end else if (pick >= 0) begin
      e_we = 1; e_addr = m_addr[pick]; e_data = m_data[pick];
    end
    e_pend = 0; e_stall = 0;
    for (int i = 0; i < 2; i++) begin
      if (m_full[i]) begin
        e_pend[m_addr[i]] = 1'b1;
        if (m_wait[i] >= Limit) e_stall = 1;
      end
    end
    check_eq("we", {31'd0, we}, {31'd0, e_we});
    check_eq("waddr", {27'd0, waddr}, {27'd0, e_addr});
    check_eq("wdata", wdata, e_data);
    check_eq("stall", {31'd0, stall_o}, {31'd0, e_stall});
    check_eq("pend", pend_mask, e_pend);
    check_eq("md_ready", {31'd0, md_ready}, {31'd0, !m_full[0]});
    check_eq("ld_ready", {31'd0, ld_ready}, {31'd0, !m_full[1]});

    xv[0] = mv; xa[0] = ma; xd[0] = mdat;
    xv[1] = lv; xa[1] = la; xd[1] = ldat;
    for (int i = 0; i < 2; i++) begin
      if (m_full[i]) begin
        if (pick == i) m_full[i] = 0;
        else if (m_wait[i] < 15) m_wait[i]++;
      end else if (xv[i] && xa[i] != 0) begin
        m_full[i] = 1; m_addr[i] = xa[i]; m_data[i] = xd[i];
        m_wait[i] = 0; m_seq[i] = seq_ctr; seq_ctr++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) run_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    seq_ctr = 0;
    model_reset();
    rst = 1'b0;
    p_we = 0; p_waddr = 0; p_wdata = 0;
    md_valid = 0; md_waddr = 0; md_wdata = 0;
    ld_valid = 0; ld_waddr = 0; ld_wdata = 0;
    #2;
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single mul-div write to r5.
    run_cycle(0, 0, 0, 1, 5'd5, 32'h11, 0, 0, 0);
    idle(2);
    // Load then mul-div to r7 in consecutive cycles.
    run_cycle(0, 0, 0, 0, 0, 0, 1, 5'd7, 32'haa);
    run_cycle(0, 0, 0, 1, 5'd7, 32'hbb, 0, 0, 0);
    idle(3);
    // Starvation under continuous pipeline writes to r3, then release.
    run_cycle(1, 5'd3, 32'h1, 1, 5'd9, 32'h99, 0, 0, 0);
    for (int k = 0; k < 6; k++) run_cycle(1, 5'd3, 32'h100 + k, 0, 0, 0, 0, 0, 0);
    idle(2);
    // Load-return request to r0 is dropped.
    run_cycle(0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hdead);
    idle(2);
    // Pipeline enable with r0 does not block a buffered write.
    run_cycle(1, 5'd3, 32'h5, 1, 5'd4, 32'h44, 0, 0, 0);
    run_cycle(1, 5'd0, 32'h6, 0, 0, 0, 0, 0, 0);
    idle(1);
    // Both buffers accepted in the same cycle, same address.
    run_cycle(1, 5'd2, 32'h7, 1, 5'd6, 32'h61, 1, 5'd6, 32'h62);
    idle(3);

    // Randomized traffic with alternating pipeline pressure.
    for (int k = 0; k < 3000; k++) begin
      int unsigned pct;
      pct = ((k / 200) % 2 == 0) ? 40 : 92;
      run_cycle($urandom_range(99, 0) < pct, 5'($urandom_range(7, 0)), $urandom,
                $urandom_range(2, 0) != 0, 5'($urandom_range(7, 0)), $urandom,
                $urandom_range(2, 0) != 0, 5'($urandom_range(7, 0)), $urandom);
    end

    // Fill both buffers while the pipeline holds the port, then reset mid-cycle.
    idle(2);
    run_cycle(1, 5'd3, 32'h1, 1, 5'd10, 32'ha0, 1, 5'd11, 32'hb0);
    p_we = 1; p_waddr = 5'd3; p_wdata = 32'h2;
    md_valid = 0; ld_valid = 0;
    check_eq("pre_rst_pend", pend_mask, 32'h0000_0c00);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    idle(4);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 Parameter: STARVE_LIMIT, 4, cycles a buffered write may wait before stall_o asserts (legal range 1..15).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-low reset (rst==0 resets).
REQ-004 p_we  input  1  main-pipeline write-back enable; never back-pressured.
REQ-005 p_waddr  input  5  pipeline destination register.
REQ-006 p_wdata  input  32  pipeline write data.
REQ-007 md_valid / md_ready  input / output  1 / 1  mul-div write request handshake.
REQ-008 md_waddr / md_wdata  input  5 / 32  mul-div destination and data.
REQ-009 ld_valid / ld_ready  input / output  1 / 1  load-return write request handshake.
REQ-010 ld_waddr / ld_wdata  input  5 / 32  load-return destination and data.
REQ-011 we / waddr / wdata  output  1 / 5 / 32  register-file write port.
REQ-012 stall_o  output  1  asks the pipeline to hold p_we low next cycle.
REQ-013 pend_mask  output  32  bit i set = register i has a buffered, not-yet-written write.

Function
REQ-014 Each secondary requester (md, ld) has one 1-entry buffer: valid bit, 5-bit address, 32-bit data, 4-bit wait counter.
REQ-015 x_ready = buffer empty (registered state); no same-cycle drain-and-refill.
REQ-016 Transfer on x_valid && x_ready at posedge: buffer loads x_waddr/x_wdata, becomes full, wait counter = 0.
REQ-017 Request with x_waddr==0: accepted per handshake, discarded (buffer stays empty, no write issued).
REQ-018 Port priority per cycle (combinational): (1) pipeline if p_we && p_waddr!=0; (2) else oldest full buffer; (3) else idle.
REQ-019 Age: per-entry age bit set at acceptance. If both buffers full, the earlier-accepted one is granted first; same-cycle acceptance -> md first.
REQ-020 Granted buffer drives we=1, waddr/wdata from buffer, and becomes empty at the following posedge.
REQ-021 Idle port: we=0, waddr=0, wdata=0.
REQ-022 Minimum latency: accepted at edge N -> we asserted in cycle N..N+1, written by regfile at edge N+1.
REQ-023 Wait counter increments each cycle its buffer is full and not granted; saturates at 15.
REQ-024 stall_o = 1 while any full buffer has wait counter >= STARVE_LIMIT; combinational from registered state.
REQ-025 If p_we remains high while stall_o=1, pipeline still wins; counters saturate, no data lost.
REQ-026 With p_we low and stall_o=1, the oldest starving buffer is granted that cycle.
REQ-027 pend_mask = OR of one-hot(addr) over full buffers; both buffers with same address set one bit.
REQ-028 Pipeline write to an address pending in a buffer is not filtered; decode shall use pend_mask to prevent this hazard.
REQ-029 Both buffers same address: written in age order; last write = younger request.

Reset
REQ-030 rst==0 immediately: buffers empty, counters 0, age bits cleared; md_ready=ld_ready=1, we=0, waddr=0, wdata=0, stall_o=0, pend_mask=0.
REQ-031 Reset mid-operation discards buffered writes; no partial write after release.
REQ-032 First handshake is possible at the first posedge with rst==1.

Verification
REQ-033 md_valid, md_waddr=5, md_wdata=0x11, p_we=0 -> next cycle we=1, waddr=5, wdata=0x11, pend_mask bit 5 set; following cycle md_ready=1, pend_mask=0.
REQ-034 ld accepted cycle 0 (r7), md accepted cycle 1 (r7), p_we=0 -> r7 written 0x(ld) then 0x(md) in consecutive cycles.
REQ-035 md buffered, p_we=1 continuously to r3 -> stall_o rises after 4 waiting cycles; drop p_we -> md granted same cycle, stall_o falls next cycle.
REQ-036 ld_valid with ld_waddr=0 -> ld_ready stays 1, we never asserted for it, pend_mask=0.
REQ-037 Both buffers full, assert rst=0 asynchronously mid-cycle -> outputs reach reset values without a clock edge; after release no write occurs.
REQ-038 p_we=1, p_waddr=0, md buffer full -> md granted that cycle.
